// File: rtl/mic_capture_pkg.sv
// ---------------------------------------------------------------------------
// mic_capture_pkg
// Shared definitions for the microphone ADC capture path: serial frame
// geometry, sample width, FSM state encoding and default timing parameters.
// No ports.
// ---------------------------------------------------------------------------
package mic_capture_pkg;

    localparam int FRAME_BITS         = 16;    // SCLK periods / bits per ADC frame
    localparam int DATA_BITS          = 12;    // sample bits kept from each frame
    localparam int CLK_DIV_DEFAULT    = 3;     // clk cycles per SCLK half-period
    localparam int SAMPLE_DIV_DEFAULT = 5000;  // clk cycles between frame starts

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cap_state_t;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mic_capture_if.sv
// ---------------------------------------------------------------------------
// mic_capture_if
// Bundles the ADC serial link (miso, cs, sclk) with the captured sample
// (mic_in, sample_valid).
//   master : the capture block -- drives cs/sclk/mic_in/sample_valid, reads miso
//   slave  : the ADC / downstream side -- drives miso, observes the rest
// ---------------------------------------------------------------------------
interface mic_capture_if;
    import mic_capture_pkg::*;

    logic                 miso;
    logic                 cs;
    logic                 sclk;
    logic [DATA_BITS-1:0] mic_in;
    logic                 sample_valid;

    modport master (
        input  miso,
        output cs,
        output sclk,
        output mic_in,
        output sample_valid
    );

    modport slave (
        output miso,
        input  cs,
        input  sclk,
        input  mic_in,
        input  sample_valid
    );

endinterface

// File: rtl/mic_capture_clk_div_en.sv
// ---------------------------------------------------------------------------
// clk_div_en
// SCLK timing generator. While en is high it counts CLK_DIV clk cycles per
// SCLK half-period and emits a one-cycle fall_en, then rise_en, alternating,
// starting with a fall. No clock is derived; the parent registers sclk.
//   clk, reset : system clock, synchronous active-high reset
//   en         : run the divider; low clears the count and phase
//   rise_en    : this cycle produces an sclk rising edge
//   fall_en    : this cycle produces an sclk falling edge
// ---------------------------------------------------------------------------
module clk_div_en
    import mic_capture_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_en,
    output logic fall_en
);

    localparam int            CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase;  // 0: next toggle is a fall, 1: next toggle is a rise
    logic          tick;

    assign tick    = en && (cnt == TC);
    assign fall_en = tick && !phase;
    assign rise_en = tick && phase;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mic_capture.sv
// ---------------------------------------------------------------------------
// mic_capture
// Periodically reads one 16-bit frame from the microphone ADC over a
// 3-wire serial link and presents the low 12 bits as mic_in, with a
// one-cycle sample_valid pulse on each update.
//   clk, reset : system clock, synchronous active-high reset
//   adc        : mic_capture_if.master (miso in; cs, sclk, mic_in,
//                sample_valid out, all registered)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cs high, sclk high, waiting for the sample timer to wrap
// ST_SHIFT | cs low, 16 SCLK periods, one miso bit taken per rising edge
// ST_DONE  | cs high for one cycle, captured word moves to mic_in
// ---------------------------------------------------------------------------
module mic_capture
    import mic_capture_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    mic_capture_if.master adc
);

    localparam int            TW         = cnt_width(SAMPLE_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
    localparam int            BW         = cnt_width(FRAME_BITS);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);

    cap_state_t           state, state_nxt;
    logic [TW-1:0]        timer;
    logic                 trigger;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift_act;
    logic                 rise_en, fall_en;
    logic                 cs_nxt, sclk_nxt;
    logic                 cs_q, sclk_q, sv_q;
    logic [DATA_BITS-1:0] mic_q;

    // Free-running frame timer; its wrap cycle is the frame trigger. A trigger
    // seen outside ST_IDLE is simply ignored.
    assign trigger = (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset || trigger) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    assign shift_act = (state == ST_SHIFT);

    clk_div_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div_en (
        .clk     (clk),
        .reset   (reset),
        .en      (shift_act),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cs_nxt    = 1'b1;
        sclk_nxt  = 1'b1;
        unique case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_SHIFT;
            ST_SHIFT: if (rise_en && (bit_cnt == LAST_BIT)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so cs/sclk land in their
        // registers on the same edge as the state change.
        if (state_nxt == ST_SHIFT) begin
            cs_nxt = 1'b0;
            if (fall_en) begin
                sclk_nxt = 1'b0;
            end else if (rise_en) begin
                sclk_nxt = 1'b1;
            end else begin
                sclk_nxt = sclk_q;
            end
        end
    end

    // Only DATA_BITS wide: shifting all 16 bits through it leaves the 12 data
    // bits in place and lets the 4 leading bits fall off the top unchecked.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (shift_act) begin
            if (rise_en) begin
                shreg   <= {shreg[DATA_BITS-2:0], adc.miso};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end else begin
            bit_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            mic_q  <= '0;
            sv_q   <= 1'b0;
        end else begin
            cs_q   <= cs_nxt;
            sclk_q <= sclk_nxt;
            sv_q   <= (state == ST_DONE);
            if (state == ST_DONE) begin
                mic_q <= shreg;
            end
        end
    end

    assign adc.cs           = cs_q;
    assign adc.sclk         = sclk_q;
    assign adc.mic_in       = mic_q;
    assign adc.sample_valid = sv_q;

endmodule

// File: tb/tb_mic_capture.sv
// ---------------------------------------------------------------------------
// tb_mic_capture
// Two captures share clk/reset: A with a legal frame period (200), B with a
// period too short for a frame (50), so B must skip every other trigger.
// A timeline model predicts, per cycle, cs, sclk, sample_valid and mic_in
// from the frame period, the divider and the word list fed to each ADC model.
// ---------------------------------------------------------------------------
module tb_mic_capture;
    import mic_capture_pkg::*;

    localparam int CD        = 3;
    localparam int SD_A      = 200;
    localparam int SD_B      = 50;
    localparam int NW        = 64;
    localparam int FRAME_CYC = 2 * FRAME_BITS * CD;  // cs-low cycles per frame

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mic_capture_if if_a ();
    mic_capture_if if_b ();

    mic_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SD_A)) dut_a (.clk(clk), .reset(reset), .adc(if_a));
    mic_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SD_B)) dut_b (.clk(clk), .reset(reset), .adc(if_b));

    logic        miso_drv [2] = '{1'b0, 1'b0};
    logic        cs_o     [2];
    logic        sclk_o   [2];
    logic        sv_o     [2];
    logic [11:0] mic_o    [2];

    assign if_a.miso = miso_drv[0];
    assign if_b.miso = miso_drv[1];
    assign cs_o[0]   = if_a.cs;
    assign cs_o[1]   = if_b.cs;
    assign sclk_o[0] = if_a.sclk;
    assign sclk_o[1] = if_b.sclk;
    assign sv_o[0]   = if_a.sample_valid;
    assign sv_o[1]   = if_b.sample_valid;
    assign mic_o[0]  = if_a.mic_in;
    assign mic_o[1]  = if_b.mic_in;

    logic [15:0] words [2][NW];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sd_of(input int i);
        return (i == 0) ? SD_A : SD_B;
    endfunction

    // ---------------- reference timeline (updated on each clk edge) --------
    int          idx        [2] = '{0, 0};
    int          ws         [2] = '{-1000000, -1000000};
    int          sv_at      [2] = '{-1, -1};
    int          busy_until [2] = '{0, 0};
    int          nf_m       [2] = '{0, 0};
    logic [15:0] word_m     [2];
    logic [11:0] exp_mic    [2];
    bit          live    = 1'b0;
    bit          rst_hit = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            rst_hit = reset;
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    idx[i]        = 0;
                    ws[i]         = -1000000;
                    sv_at[i]      = -1;
                    busy_until[i] = 0;
                    exp_mic[i]    = '0;
                end else begin
                    // Cycle idx just ended: a timer wrap starts a frame only if
                    // the previous frame has fully finished.
                    if ((idx[i] % sd_of(i)) == sd_of(i) - 1 && idx[i] >= busy_until[i]) begin
                        ws[i]         = idx[i] + 1;
                        sv_at[i]      = idx[i] + FRAME_CYC + 2;
                        busy_until[i] = sv_at[i];
                        word_m[i]     = words[i][nf_m[i] % NW];
                        nf_m[i]++;
                    end
                    idx[i]++;
                    if (idx[i] == sv_at[i]) exp_mic[i] = word_m[i][11:0];
                end
            end
            if (reset) live = 1'b1;
        end
    end

    // ---------------- ADC models: new word per cs fall, bit per sclk fall --
    initial begin
        logic        pc [2];
        logic        ps [2];
        int          bi [2];
        int          nf [2];
        logic [15:0] w  [2];
        for (int i = 0; i < 2; i++) begin
            pc[i] = 1'b1; ps[i] = 1'b1; bi[i] = -1; nf[i] = 0; w[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cs_o[i] == 1'b0 && pc[i] == 1'b1) begin
                    w[i]  = words[i][nf[i] % NW];
                    nf[i]++;
                    bi[i] = 15;
                end
                if (cs_o[i] == 1'b0 && sclk_o[i] == 1'b0 && ps[i] == 1'b1 && bi[i] >= 0) begin
                    miso_drv[i] = w[i][bi[i]];
                    bi[i]--;
                end
                pc[i] = cs_o[i];
                ps[i] = sclk_o[i];
            end
        end
    end

    // ---------------- per-cycle comparison and edge monitor ---------------
    int   sv_cnt     [2] = '{0, 0};
    int   exp_sv_cnt [2] = '{0, 0};
    int   rises      [2] = '{0, 0};
    logic prev_cs    [2] = '{1'b1, 1'b1};
    logic prev_sclk  [2] = '{1'b1, 1'b1};
    int   gcyc    = 0;
    int   last_sv = -1;

    initial begin
        bit   in_win;
        logic exp_sclk;
        int   j;
        forever begin
            @(negedge clk);
            gcyc++;
            if (live) begin
                for (int i = 0; i < 2; i++) begin
                    in_win   = (idx[i] >= ws[i]) && (idx[i] < ws[i] + FRAME_CYC);
                    j        = idx[i] - ws[i];
                    exp_sclk = in_win ? (((j / CD) % 2) == 0) : 1'b1;
                    check_eq($sformatf("cs%0d", i),   32'(cs_o[i]),   32'(!in_win));
                    check_eq($sformatf("sclk%0d", i), 32'(sclk_o[i]), 32'(exp_sclk));
                    check_eq($sformatf("sv%0d", i),   32'(sv_o[i]),   32'(idx[i] == sv_at[i]));
                    check_eq($sformatf("mic%0d", i),  32'(mic_o[i]),  32'(exp_mic[i]));
                    if (idx[i] == sv_at[i]) exp_sv_cnt[i]++;
                    if (sv_o[i] === 1'b1) sv_cnt[i]++;

                    if (rst_hit) begin
                        rises[i] = 0;
                    end else begin
                        if (sclk_o[i] == 1'b1 && prev_sclk[i] == 1'b0 && prev_cs[i] == 1'b0)
                            rises[i]++;
                        if (cs_o[i] == 1'b1 && prev_cs[i] == 1'b1)
                            check_eq($sformatf("sclk_idle%0d", i), 32'(sclk_o[i]), 32'(prev_sclk[i]));
                        if (cs_o[i] == 1'b1 && prev_cs[i] == 1'b0) begin
                            check_eq($sformatf("rises%0d", i), 32'(rises[i]), 32'(FRAME_BITS));
                            rises[i] = 0;
                        end
                    end
                    prev_cs[i]   = cs_o[i];
                    prev_sclk[i] = sclk_o[i];
                end
                if (rst_hit) begin
                    last_sv = -1;
                end else if (sv_o[0] === 1'b1) begin
                    if (last_sv >= 0) check_eq("sv_gap_a", 32'(gcyc - last_sv), 32'(SD_A));
                    last_sv = gcyc;
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit   got;
        int   nr;
        logic ps;

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NW; k++)
                words[i][k] = 16'($urandom_range(0, 65535));
        words[0][0] = 16'h0ABC;
        words[0][1] = 16'h0FFF;
        words[0][2] = 16'h0000;
        words[0][3] = 16'hF123;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        repeat (4 * SD_A + 150) step();

        // Abort a frame on A at its 8th sclk rising edge.
        got = 1'b0;
        for (int k = 0; k < 2 * SD_A && !got; k++) begin
            if (if_a.cs == 1'b0) got = 1'b1;
            else step();
        end
        check_eq("wait_cs_low", 32'(got), 32'(1));
        nr = 0;
        ps = if_a.sclk;
        for (int k = 0; k < FRAME_CYC && nr < 8; k++) begin
            step();
            if (if_a.sclk == 1'b1 && ps == 1'b0) nr++;
            ps = if_a.sclk;
        end
        check_eq("wait_rise8", 32'(nr), 32'(8));

        reset = 1'b1;
        step();
        check_eq("abort_cs",   32'(if_a.cs),           32'(1));
        check_eq("abort_sclk", 32'(if_a.sclk),         32'(1));
        check_eq("abort_mic",  32'(if_a.mic_in),       32'(0));
        check_eq("abort_sv",   32'(if_a.sample_valid), 32'(0));
        reset = 1'b0;

        repeat (6 * SD_A + 20) step();

        // Reset at an arbitrary point, then run on.
        repeat ($urandom_range(40, 400)) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6 * SD_A + 20) step();

        for (int i = 0; i < 2; i++)
            check_eq($sformatf("sv_count%0d", i), 32'(sv_cnt[i]), 32'(exp_sv_cnt[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mic_capture.md
MIC_CAPTURE -- requirements
Module: mic_capture

Interface
REQ-001 Parameter CLK_DIV, default 3: CLK cycles per SCLK half-period (100 MHz CLK -> 16.67 MHz SCLK).
REQ-002 Parameter SAMPLE_DIV, default 5000: CLK cycles between frame starts (20 kHz sample rate).
REQ-003 CLK  input  1  system clock, 100 MHz; sole clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MISO  input  1  serial data from the microphone ADC; MSB first, 4 leading zeros, then 12 data bits.
REQ-006 cs  output  1  ADC chip select, active low.
REQ-007 sclk  output  1  ADC serial clock; idles high.
REQ-008 mic_in  output  12  last complete sample; drives the downstream LED gating stage.
REQ-009 sample_valid  output  1  one-CLK pulse when mic_in updates.

Function
REQ-010 Sample timer SHALL count 0..SAMPLE_DIV-1 and wrap; the wrap cycle is the frame trigger.
REQ-011 FSM states: IDLE (cs=1, sclk=1), SHIFT (cs=0, 16 SCLK periods), DONE (cs=1, one CLK).
REQ-012 IDLE->SHIFT on trigger; cs falls in the cycle after the trigger.
REQ-013 In SHIFT, sclk SHALL toggle every CLK_DIV CLK cycles, starting with a falling edge CLK_DIV cycles after cs falls.
REQ-014 MISO SHALL be sampled on the CLK cycle that produces each sclk rising edge; exactly 16 bits are captured per frame.
REQ-015 SHIFT->DONE after the 16th rising edge; cs returns high in that cycle; sclk remains high.
REQ-016 In DONE: mic_in <= bits [11:0] of the 16-bit word; the 4 leading bits are discarded without checking; sample_valid=1 for exactly this cycle; then go to IDLE.
REQ-017 mic_in SHALL hold its value between DONE cycles.
REQ-018 A trigger arriving in SHIFT or DONE SHALL be dropped, not queued; the timer keeps running.
REQ-019 SAMPLE_DIV >= 32*CLK_DIV+4 is a legal-configuration rule; with it, no trigger is ever dropped.
REQ-020 Frame latency: trigger to sample_valid = 32*CLK_DIV+2 CLK cycles.

Reset
REQ-021 When reset=1 at a CLK edge: FSM->IDLE, timer=0, bit counter=0, SCLK divider=0, shift register=0.
REQ-022 Reset values: cs=1, sclk=1, mic_in=0, sample_valid=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame in the same edge; no partial sample reaches mic_in.
REQ-024 After reset deasserts, the first trigger occurs SAMPLE_DIV-1 cycles later.

Structure
REQ-025 The frame length (16), data width (12), and FSM state encodings SHALL live in a shared audio package, together with the default CLK_DIV and SAMPLE_DIV.
REQ-026 The SCLK divider SHALL be one sub-module, clk_div_en, which outputs one-cycle rise and fall enables; no derived clocks are used.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 ADC model returns 0x0ABC; CLK_DIV=3, SAMPLE_DIV=200 -> mic_in=0xABC and sample_valid pulses once, 98 cycles after the trigger.
REQ-029 Consecutive words 0x0FFF then 0x0000 -> mic_in=0xFFF, then 0x000; sample_valid pulses are exactly 200 cycles apart.
REQ-030 Model drives leading nibble 0xF (word 0xF123) -> mic_in=0x123.
REQ-031 reset pulsed at SCLK edge 8 of a frame -> next cycle cs=1, sclk=1, mic_in=0; no sample_valid until the next full frame.
REQ-032 SAMPLE_DIV=50, CLK_DIV=3 (illegal) -> every second trigger is dropped; each captured frame is still intact and contains 16 rising edges.
REQ-033 Across all frames, check: sclk is constant while cs=1, and exactly 16 sclk rising edges occur per cs-low window.
